// File: rtl/vc_sched6.sv
// -----------------------------------------------------------------------------
// vc_sched6 -- oldest-first scheduler sharing one router output port among six
// virtual channels.
//
// Each cycle the eligible VC (head flit present, downstream credit available)
// with the smallest injection timestamp is popped into a one-entry output
// register. A VC that has waited STARVE_LIMIT cycles overrides the age choice.
// The output register hands off to switch traversal with valid/ready.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   [5:0]  VC i holds a head flit
//   req_time    [6*TIME_WIDTH-1:0]  head-flit timestamp of VC i at [i*TIME_WIDTH +: TIME_WIDTH]
//   credit_ret  [5:0]  one-cycle pulse returns one downstream credit for VC i
//   out_ready   downstream accepts the output register this cycle
//   req_pop     [5:0]  combinational one-hot pop of the granted VC's head flit
//   out_valid   output register holds a granted flit
//   out_vc      index of the granted VC
//   out_time    timestamp of the granted flit
//   credit_err  sticky: credit returned to a VC whose counter was already full
// -----------------------------------------------------------------------------
module vc_sched6 #(
   parameter int TIME_WIDTH     = 8,
   parameter int VC_INDEX_WIDTH = 3,
   parameter int CREDIT_DEPTH   = 4,
   parameter int STARVE_LIMIT   = 15
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [5:0]                  req_valid,
   input  logic [6*TIME_WIDTH-1:0]     req_time,
   input  logic [5:0]                  credit_ret,
   input  logic                        out_ready,
   output logic [5:0]                  req_pop,
   output logic                        out_valid,
   output logic [VC_INDEX_WIDTH-1:0]   out_vc,
   output logic [TIME_WIDTH-1:0]       out_time,
   output logic                        credit_err
);

   localparam int NUM_VC = 6;
   localparam int CRED_W = 3;   // holds 0..7
   localparam int WAIT_W = 8;   // holds 0..255

   typedef logic [CRED_W-1:0]         cred_t;
   typedef logic [WAIT_W-1:0]         wait_t;
   typedef logic [VC_INDEX_WIDTH-1:0] vc_t;
   typedef logic [TIME_WIDTH-1:0]     time_t;

   localparam cred_t CRED_FULL = cred_t'(CREDIT_DEPTH);
   localparam wait_t WAIT_MAX  = wait_t'(STARVE_LIMIT);

   cred_t credit_q [NUM_VC];
   cred_t credit_d [NUM_VC];
   wait_t wait_q   [NUM_VC];
   wait_t wait_d   [NUM_VC];

   logic  out_valid_q, out_valid_d;
   vc_t   out_vc_q,    out_vc_d;
   time_t out_time_q,  out_time_d;
   logic  credit_err_q, credit_err_d;

   logic [NUM_VC-1:0] elig;
   logic [NUM_VC-1:0] grant_vec;
   logic              load;
   logic              any_elig;
   logic              starve_found;
   vc_t               age_idx;
   vc_t               starve_idx;
   vc_t               sel_idx;
   time_t             best_time;
   time_t             sel_time;

   // Arbitration: starvation override first, otherwise minimum timestamp.
   always_comb begin
      load         = !out_valid_q || out_ready;
      elig         = '0;
      any_elig     = 1'b0;
      age_idx      = '0;
      best_time    = '0;
      starve_found = 1'b0;
      starve_idx   = '0;

      for (int i = 0; i < NUM_VC; i++) begin
         elig[i] = req_valid[i] && (credit_q[i] != '0);
      end

      // Strict less-than keeps the lower index on ties.
      for (int i = 0; i < NUM_VC; i++) begin
         if (elig[i]) begin
            if (!any_elig || (req_time[i*TIME_WIDTH +: TIME_WIDTH] < best_time)) begin
               age_idx   = vc_t'(i);
               best_time = req_time[i*TIME_WIDTH +: TIME_WIDTH];
            end
            any_elig = 1'b1;
         end
      end

      // Scan downward so the lowest starving index is the one left standing.
      for (int i = NUM_VC - 1; i >= 0; i--) begin
         if (elig[i] && (wait_q[i] == WAIT_MAX)) begin
            starve_found = 1'b1;
            starve_idx   = vc_t'(i);
         end
      end

      sel_idx  = starve_found ? starve_idx : age_idx;
      sel_time = req_time[int'(sel_idx)*TIME_WIDTH +: TIME_WIDTH];

      grant_vec = '0;
      if (load && any_elig && rst_n) begin
         grant_vec[sel_idx] = 1'b1;
      end
   end

   // Output register, credit counters and wait counters.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_vc_d     = out_vc_q;
      out_time_d   = out_time_q;
      credit_err_d = credit_err_q;

      if (load) begin
         out_valid_d = any_elig;
         if (any_elig) begin
            out_vc_d   = sel_idx;
            out_time_d = sel_time;
         end
      end

      for (int i = 0; i < NUM_VC; i++) begin
         credit_d[i] = credit_q[i];
         case ({grant_vec[i], credit_ret[i]})
            2'b10:   credit_d[i] = credit_q[i] - cred_t'(1);
            2'b01: begin
               // A return on a full counter is an upstream protocol error; keep the count.
               if (credit_q[i] == CRED_FULL) begin
                  credit_err_d = 1'b1;
               end else begin
                  credit_d[i] = credit_q[i] + cred_t'(1);
               end
            end
            default: credit_d[i] = credit_q[i];
         endcase

         // Waiting counts even while credit-starved or while the output is stalled.
         if (!req_valid[i] || grant_vec[i]) begin
            wait_d[i] = '0;
         end else if (wait_q[i] != WAIT_MAX) begin
            wait_d[i] = wait_q[i] + wait_t'(1);
         end else begin
            wait_d[i] = wait_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_vc_q     <= '0;
         out_time_q   <= '0;
         credit_err_q <= 1'b0;
         for (int i = 0; i < NUM_VC; i++) begin
            credit_q[i] <= CRED_FULL;
            wait_q[i]   <= '0;
         end
      end else begin
         out_valid_q  <= out_valid_d;
         out_vc_q     <= out_vc_d;
         out_time_q   <= out_time_d;
         credit_err_q <= credit_err_d;
         for (int i = 0; i < NUM_VC; i++) begin
            credit_q[i] <= credit_d[i];
            wait_q[i]   <= wait_d[i];
         end
      end
   end

   assign req_pop    = grant_vec;
   assign out_valid  = out_valid_q;
   assign out_vc     = out_vc_q;
   assign out_time   = out_time_q;
   assign credit_err = credit_err_q;

endmodule
